// File: rtl/bit_packer.sv
// Variable-length bit packer: concatenates 0..IN_W-bit fields into dense OUT_W-bit words.
// Define BIT_PACKER_MSB_FIRST_EN for MSB-first packing; LSB-first by default.
module bit_packer #(
    parameter  int unsigned OUT_W = 64,
    parameter  int unsigned IN_W  = 64,
    localparam int unsigned SW    = $clog2(IN_W) + 1,
    localparam int unsigned BW    = $clog2(OUT_W) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [SW-1:0]     in_size,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [BW-1:0]     out_bits,
    output logic [OUT_W-1:0]  out_data
);

    localparam int unsigned CW = BW - 1;
    localparam int unsigned WW = 2 * OUT_W;

    if (IN_W < 1 || IN_W > OUT_W || OUT_W < 8 || (OUT_W & (OUT_W - 1)) != 0) begin : g_param_check
        $error("bit_packer: illegal OUT_W/IN_W combination");
    end

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state;
    logic [OUT_W-1:0]  acc;
    logic [CW-1:0]     cnt;

    logic              out_free_c;
    logic              in_fire_c;
    logic [SW-1:0]     size_c;
    logic [IN_W-1:0]   field_c;
    logic [BW-1:0]     t_c;
    logic              wrap_c;
    logic [WW-1:0]     cat_c;
    logic [OUT_W-1:0]  word_c;
    logic [OUT_W-1:0]  rem_c;

    assign out_free_c = ~out_valid | out_ready;
    assign in_ready   = ~reset & (state == RUN) & out_free_c;
    assign in_fire_c  = in_valid & in_ready;

    // Merge the masked field with held bits in a 2*OUT_W window; one half is
    // the completed word, the other the carry-over into the accumulator.
    always_comb begin
        size_c  = (in_size > SW'(IN_W)) ? SW'(IN_W) : in_size;
        field_c = in_data & ~({IN_W{1'b1}} << size_c);
        t_c     = BW'(cnt) + BW'(size_c);
        wrap_c  = t_c[BW-1];
`ifdef BIT_PACKER_MSB_FIRST_EN
        cat_c   = {acc, {OUT_W{1'b0}}} | (WW'(field_c) << ((BW+1)'(WW) - (BW+1)'(t_c)));
        word_c  = cat_c[WW-1:OUT_W];
        rem_c   = cat_c[OUT_W-1:0];
`else
        cat_c   = {{OUT_W{1'b0}}, acc} | (WW'(field_c) << cnt);
        word_c  = cat_c[OUT_W-1:0];
        rem_c   = cat_c[WW-1:OUT_W];
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_bits  <= '0;
            out_data  <= '0;
        end else begin
            // Beat drained with nothing new loaded this cycle.
            if (out_free_c) begin
                out_valid <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (in_fire_c) begin
                        if (wrap_c) begin
                            out_valid <= 1'b1;
                            out_data  <= word_c;
                            out_bits  <= BW'(OUT_W);
                            acc       <= rem_c;
                            cnt       <= t_c[CW-1:0];
                            out_last  <= in_last && (t_c[CW-1:0] == '0);
                            if (in_last && (t_c[CW-1:0] != '0)) begin
                                state <= FLUSH;
                            end
                        end else if (in_last) begin
                            out_valid <= 1'b1;
                            out_data  <= word_c;
                            out_bits  <= t_c;
                            out_last  <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                        end else begin
                            acc <= word_c;
                            cnt <= t_c[CW-1:0];
                        end
                    end
                end
                FLUSH: begin
                    if (out_free_c) begin
                        out_valid <= 1'b1;
                        out_data  <= acc;
                        out_bits  <= BW'(cnt);
                        out_last  <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_packer.sv
// Directed + random bench for bit_packer with a bit-queue reference model and scoreboard.
module tb_bit_packer;

    localparam int OUT_W = 64;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [6:0]  in_size;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [6:0]  out_bits;
    logic [63:0] out_data;

    typedef struct packed {
        logic [63:0] data;
        logic [6:0]  bits;
        logic        last;
    } beat_t;

    bit    bq[$];
    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    bit    rand_bp = 0;

    bit_packer #(.OUT_W(64), .IN_W(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_size   (in_size),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_bits  (out_bits),
        .out_data  (out_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Pop n bits from the model bit stream into one expected beat.
    task automatic emit(input int n, input bit last);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < n; i++) begin
`ifdef BIT_PACKER_MSB_FIRST_EN
            b.data[OUT_W-1-i] = bq.pop_front();
`else
            b.data[i] = bq.pop_front();
`endif
        end
        b.bits = 7'(n);
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic model_push(input int size, input logic [63:0] data, input bit last);
        int n;
        bit emitted;
        beat_t b;
        n = (size > 64) ? 64 : size;
`ifdef BIT_PACKER_MSB_FIRST_EN
        for (int i = n - 1; i >= 0; i--) bq.push_back(data[i]);
`else
        for (int i = 0; i < n; i++) bq.push_back(data[i]);
`endif
        emitted = 0;
        if (bq.size() >= OUT_W) begin
            emit(OUT_W, 1'b0);
            emitted = 1;
        end
        if (last) begin
            if (bq.size() == 0 && emitted) begin
                b = exp_q.pop_back();
                b.last = 1'b1;
                exp_q.push_back(b);
            end else begin
                emit(bq.size(), 1'b1);
            end
        end
    endtask

    task automatic send(input int size, input logic [63:0] data, input bit last);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_size  = 7'(size);
        in_data  = data;
        in_last  = last;
        for (int c = 0; c < 200 && !ok; c++) begin
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            if (in_ready) ok = 1;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("send_accepted", 64'(ok), 64'd1);
        if (ok) model_push(size, data, last);
    endtask

    // Scoreboard: compare every consumed beat against the model, in order.
    always @(negedge clock) begin
        beat_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", out_data, e.data);
                chk("sb_bits", 64'(out_bits), 64'(e.bits));
                chk("sb_last", 64'(out_last), 64'(e.last));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_size   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_bits", 64'(out_bits), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        step();
        reset = 1'b0;

        // Two 40-bit fields produce one full word, 16 bits left over.
        send(40, 64'hFF_FFFF_FFFF, 0);
        send(40, 64'h12_3456_789A, 0);
        @(negedge clock);
        chk("pack_valid", 64'(out_valid), 64'd1);
`ifndef BIT_PACKER_MSB_FIRST_EN
        chk("pack_data", out_data, 64'h5678_9AFF_FFFF_FFFF);
        chk("pack_bits", 64'(out_bits), 64'd64);
        chk("pack_last", 64'(out_last), 64'd0);
`endif
        step();
        send(0, 64'h0, 1);
        @(negedge clock);
`ifndef BIT_PACKER_MSB_FIRST_EN
        chk("leftover_data", out_data, 64'h1234);
`endif
        chk("leftover_bits", 64'(out_bits), 64'd16);
        step();

        // Flush path: one bubble cycle.
        send(40, 64'hFF_FFFF_FFFF, 0);
        send(40, 64'h12_3456_789A, 1);
        @(negedge clock);
        chk("flush_bubble_ready", 64'(in_ready), 64'd0);
`ifndef BIT_PACKER_MSB_FIRST_EN
        chk("flush_word_data", out_data, 64'h5678_9AFF_FFFF_FFFF);
`endif
        chk("flush_word_last", 64'(out_last), 64'd0);
        @(negedge clock);
        chk("flush_ready_back", 64'(in_ready), 64'd1);
`ifndef BIT_PACKER_MSB_FIRST_EN
        chk("flush_tail_data", out_data, 64'h1234);
`endif
        chk("flush_tail_bits", 64'(out_bits), 64'd16);
        chk("flush_tail_last", 64'(out_last), 64'd1);
        step();

        // Masking of bits above in_size.
        for (int i = 0; i < 16; i++) send(4, 64'hFFFF_FFFF_FFFF_FFF5, i == 15);
        @(negedge clock);
        chk("mask_data", out_data, 64'h5555_5555_5555_5555);
        chk("mask_bits", 64'(out_bits), 64'd64);
        chk("mask_last", 64'(out_last), 64'd1);
        step();

        // Empty last beat at cnt==0.
        send(0, 64'hFFFF, 1);
        @(negedge clock);
        chk("empty_valid", 64'(out_valid), 64'd1);
        chk("empty_data", out_data, 64'd0);
        chk("empty_bits", 64'(out_bits), 64'd0);
        chk("empty_last", 64'(out_last), 64'd1);
        step();
        repeat (2) step();

        // Backpressure: output holds stable and input is blocked.
        out_ready = 1'b0;
        send(64, 64'hDEAD_BEEF_0123_4567, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_data", out_data, 64'hDEAD_BEEF_0123_4567);
            chk("bp_bits", 64'(out_bits), 64'd64);
            chk("bp_last", 64'(out_last), 64'd0);
        end
        step();
        out_ready = 1'b1;
        send(12, 64'hABC, 0);
        send(52, 64'h000F_EDCB_A987_6543, 1);
        repeat (3) step();

        // Reset mid-stream with held bits and a stalled beat.
        send(24, 64'hC0FFEE, 0);
        out_ready = 1'b0;
        send(64, 64'h1111_2222_3333_4444, 0);
        reset = 1'b1;
        step();
        @(negedge clock);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_bits", 64'(out_bits), 64'd0);
        chk("mid_rst_last", 64'(out_last), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        bq.delete();
        exp_q.delete();
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        send(8, 64'hAB, 1);
        @(negedge clock);
`ifdef BIT_PACKER_MSB_FIRST_EN
        chk("restart_data", out_data, 64'hAB00_0000_0000_0000);
`else
        chk("restart_data", out_data, 64'hAB);
`endif
        chk("restart_bits", 64'(out_bits), 64'd8);
        step();

`ifdef BIT_PACKER_MSB_FIRST_EN
        send(8, 64'hAB, 0);
        send(8, 64'hCD, 1);
        @(negedge clock);
        chk("msb_data", out_data, 64'hABCD_0000_0000_0000);
        chk("msb_bits", 64'(out_bits), 64'd16);
        chk("msb_last", 64'(out_last), 64'd1);
        step();
`endif

        // Random sizes (including oversize) under random backpressure.
        rand_bp = 1;
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 127)), {$urandom, $urandom}, i == 39);
        end
        rand_bp = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
